// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_adder_pkg: group width, configuration legality check and stage-count derivation
package cla_pipe_adder_pkg;
  localparam int GROUP_W = 4;
  function automatic bit cfg_legal(int width, int gps);
    return width >= GROUP_W && width % GROUP_W == 0 && gps >= 1 && (width / GROUP_W) % gps == 0;
  endfunction
  function automatic int stages_of(int width, int gps);
    return gps >= 1 && width >= GROUP_W * gps ? width / (GROUP_W * gps) : 1;
  endfunction
endpackage

// File: rtl/cla_pipe_adder_group.sv
// cla4_group: 4-bit lookahead block; a, b, cin in; sum, group propagate p, group generate g, cout out
module cla4_group import cla_pipe_adder_pkg::*; (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               p,
  output logic               g,
  output logic               cout
);
  logic [GROUP_W-1:0] pp, gg, c;
  assign pp = a ^ b;
  assign gg = a & b;
  assign c[0] = cin;
  assign c[1] = gg[0] | pp[0] & cin;
  assign c[2] = gg[1] | pp[1] & gg[0] | pp[1] & pp[0] & cin;
  assign c[3] = gg[2] | pp[2] & gg[1] | pp[2] & pp[1] & gg[0] | pp[2] & pp[1] & pp[0] & cin;
  assign p = &pp;
  assign g = gg[3] | pp[3] & gg[2] | pp[3] & pp[2] & gg[1] | pp[3] & pp[2] & pp[1] & gg[0];
  assign cout = g | p & cin;
  assign sum = pp ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA add/sub; a, b, cin, sub enter via in_valid/in_ready, sum, cout, ovf leave via out_valid/out_ready
module cla_pipe_adder import cla_pipe_adder_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int GPS = GROUPS_PER_STAGE;
  localparam int STAGES = stages_of(WIDTH, GPS);
  localparam int SW = GROUP_W * GPS;
  if (!cfg_legal(WIDTH, GPS)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and WIDTH/4 divisible by GROUPS_PER_STAGE");
  end
  logic [STAGES-1:0][WIDTH-1:0] ra, rb, ns;
  logic [STAGES:0][WIDTH-1:0] rs;
  logic [STAGES:0] rc, rv;
  logic [STAGES-1:0] nc;
  logic cm, rm, stall, unused_ab;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall && !rst;
  assign unused_ab = ^{ra, rb};
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [GPS-1:0] gp, gg, gco, gc;
    logic [SW-1:0] gs;
    logic [WIDTH-1:0] nsv;
    logic t, unused_co;
    assign unused_co = ^gco;
    always_comb begin
      gc = '0;
      t = 1'b0;
      for (int k = 0; k < GPS; k++) begin
        gc[k] = rc[s];
        for (int m = 0; m < k; m++) gc[k] = gc[k] & gp[m];
        for (int i = 0; i < k; i++) begin
          t = gg[i];
          for (int m = i + 1; m < k; m++) t = t & gp[m];
          gc[k] = gc[k] | t;
        end
      end
    end
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_group u_grp (
        .a(ra[s][(s*GPS+j)*GROUP_W +: GROUP_W]),
        .b(rb[s][(s*GPS+j)*GROUP_W +: GROUP_W]),
        .cin(gc[j]),
        .sum(gs[j*GROUP_W +: GROUP_W]),
        .p(gp[j]),
        .g(gg[j]),
        .cout(gco[j])
      );
    end
    always_comb begin
      nsv = rs[s];
      nsv[s*SW +: SW] = gs;
    end
    assign ns[s] = nsv;
    assign nc[s] = gco[GPS-1];
  end
  assign cm = ns[STAGES-1][WIDTH-1] ^ ra[STAGES-1][WIDTH-1] ^ rb[STAGES-1][WIDTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      rv <= '0;
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (!stall) begin
      rv <= {rv[STAGES-1:0], in_valid};
      ra[0] <= a;
      rb[0] <= sub ? ~b : b;
      rc[0] <= sub | cin;
      rs[0] <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rs[i+1] <= ns[i];
        rc[i+1] <= nc[i];
      end
      for (int i = 1; i < STAGES; i++) begin
        ra[i] <= ra[i-1];
        rb[i] <= rb[i-1];
      end
      rm <= cm;
      out_valid <= rv[STAGES];
      sum <= rs[STAGES];
      cout <= rc[STAGES];
      ovf <= rc[STAGES] ^ rm;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: vectors, stall/reset sequences and random beats on several cla_pipe_adder configurations
`timescale 1ns/1ps
module tb_cla_pipe_adder;
  localparam int W = 16;
  localparam int NX = 3;
  localparam logic [NX-1:0][7:0] XW = {8'd32, 8'd16, 8'd4};
  localparam logic [NX-1:0][7:0] XG = {8'd2, 8'd1, 8'd1};
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, out_valid, out_ready = 1'b0, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [NX-1:0] xdone;
  int ncmp = 0, nfail = 0;
  typedef struct {
    logic [15:0] a, b;
    logic ci, sb;
    logic [15:0] s;
    logic co, ov;
  } vec_t;
  vec_t vt[9];
  always #5 clk = ~clk;
  cla_pipe_adder #(.WIDTH(W), .GROUPS_PER_STAGE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  function automatic logic [33:0] model(int w, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
    longint m, sx, sy, r, sr;
    logic co, ov;
    m = (longint'(1) << w) - 1;
    sx = x[w-1] ? longint'(x) - (m + 1) : longint'(x);
    sy = y[w-1] ? longint'(y) - (m + 1) : longint'(y);
    r = sb ? longint'(x) - longint'(y) : longint'(x) + longint'(y) + longint'(ci);
    sr = sb ? sx - sy : sx + sy + longint'(ci);
    co = sb ? longint'(x) >= longint'(y) : r > m;
    ov = sr > (m >> 1) || sr < -((m + 1) >> 1);
    return {ov, co, 32'(r & m)};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic one_beat(input vec_t v, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.ci; sub = v.sb; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    chk({tag, " latency"}, 64'(n), 64'd4);
    chk({tag, " sum"}, 64'(sum), 64'(v.s));
    chk({tag, " cout"}, 64'(cout), 64'(v.co));
    chk({tag, " ovf"}, 64'(ovf), 64'(v.ov));
  endtask
  task automatic rand_run(input int nb);
    logic [33:0] q[$];
    logic [33:0] e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < nb && cyc < 20 * nb + 100) begin
      @(negedge clk);
      cyc++;
      in_valid = sent < nb && $urandom_range(0, 3) != 0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(W, 32'(a), 32'(b), cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        if (q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL rnd spurious: got result %0h with no beat outstanding", sum);
        end else begin
          e = q.pop_front();
          chk("rnd result", 64'({ovf, cout, 32'(sum)}), 64'(e));
        end
      end
    end
    in_valid = 1'b0;
    chk("rnd count", 64'(got), 64'(nb));
    chk("rnd drained", 64'(q.size()), 64'd0);
  endtask
  for (genvar k = 0; k < NX; k++) begin : g_x
    localparam int XWK = int'(XW[k]);
    logic xr = 1'b1, iv = 1'b0, ir, ov, rdy = 1'b0, ci = 1'b0, sb = 1'b0, co, of, fin = 1'b0;
    logic [XWK-1:0] xa = '0, xb = '0, xs;
    assign xdone[k] = fin;
    cla_pipe_adder #(.WIDTH(XWK), .GROUPS_PER_STAGE(int'(XG[k]))) u_dut (
      .clk(clk), .rst(xr), .in_valid(iv), .in_ready(ir), .a(xa), .b(xb), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(rdy), .sum(xs), .cout(co), .ovf(of)
    );
    initial begin
      logic [33:0] q[$];
      logic [33:0] e;
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("x%0d reset out_valid", k), 64'(ov), 64'd0);
      xr = 1'b0;
      while (got < 2000 && cyc < 50000) begin
        @(negedge clk);
        cyc++;
        iv = sent < 2000 && $urandom_range(0, 3) != 0;
        xa = XWK'($urandom); xb = XWK'($urandom); ci = 1'($urandom); sb = 1'($urandom);
        rdy = $urandom_range(0, 3) != 0;
        #1;
        if (iv && ir) begin
          q.push_back(model(XWK, 32'(xa), 32'(xb), ci, sb));
          sent++;
        end
        if (ov && rdy) begin
          got++;
          if (q.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL x%0d spurious: got result %0h with no beat outstanding", k, xs);
          end else begin
            e = q.pop_front();
            chk($sformatf("x%0d result", k), 64'({of, co, 32'(xs)}), 64'(e));
          end
        end
      end
      iv = 1'b0;
      chk($sformatf("x%0d count", k), 64'(got), 64'd2000);
      fin = 1'b1;
    end
  end
  initial begin
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset sum", 64'(sum), 64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1 chk("release in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 9; i++) one_beat(vt[i], $sformatf("vec%0d", i));
    begin : stall_seq
      logic [33:0] q[$];
      logic [33:0] e;
      logic [W+1:0] prev;
      logic pst;
      int sent, got;
      sent = 0; got = 0; pst = 1'b0; prev = '0;
      for (int t = 0; t < 40 && got < 8; t++) begin
        @(negedge clk);
        in_valid = sent < 8;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        out_ready = !(t >= 5 && t < 9);
        #1;
        if (out_valid && !out_ready) begin
          chk("stall in_ready", 64'(in_ready), 64'd0);
          if (pst) chk("stall hold", 64'({ovf, cout, sum}), 64'(prev));
        end
        pst = out_valid && !out_ready;
        prev = {ovf, cout, sum};
        if (in_valid && in_ready) begin
          q.push_back(model(W, 32'(a), 32'(b), cin, sub));
          sent++;
        end
        if (out_valid && out_ready) begin
          got++;
          e = q.size() != 0 ? q.pop_front() : ~34'(0);
          chk("stall result", 64'({ovf, cout, 32'(sum)}), 64'(e));
        end
      end
      in_valid = 1'b0;
      chk("stall count", 64'(got), 64'd8);
      chk("stall sent", 64'(sent), 64'd8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush stale", 64'(out_valid), 64'd0);
    end
    one_beat(vt[1], "post-reset");
    rand_run(10000);
    for (int i = 0; i < 60000 && !(&xdone); i++) @(negedge clk);
    chk("extra configs done", 64'(&xdone), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
